l2_cache_wb: RTL and testbench
==============================

# l2_cache_wb

Parametrised write-back, write-allocate, direct-mapped L2 cache between the L1/CPU Wishbone master and the DDR controller. Tag, valid and dirty state live in an internal register array. Line data lives in the external SRAM line store. Compared with the previous L2 it adds parametrised geometry, byte-masked merge on write miss, a full-cache flush, and saturating hit/miss/write-back counters.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINE_BYTES, 64, line size in bytes (power of two); LINE_W = 8*LINE_BYTES
- INDEX_W, 8, set-index bits (2^INDEX_W lines)
- CNT_W, 32, statistics counter width
- Derived: OFF_W = log2(LINE_BYTES), TAG_W = ADDR_W-INDEX_W-OFF_W

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- ws_addr  in  ADDR_W  request address (offset bits ignored)
- ws_din  in  LINE_W  write data
- ws_dm  in  LINE_BYTES  byte write enables, 1 = write byte
- ws_stb  in  1  request strobe, held until ws_ack
- ws_we  in  1  1 = write
- ws_ack  out  1  one-cycle completion pulse
- ws_dout  out  LINE_W  read data, valid with ws_ack
- flush_req  in  1  level; start flush of all dirty lines
- flush_busy  out  1  flush in progress
- ws_DDRaddr  out  ADDR_W  line-aligned DDR address
- ws_DDRdin  out  LINE_W, ws_DDRdm  out  LINE_BYTES  write data/mask
- ws_DDRcyc, ws_DDRstb, ws_DDRwe  out  1  (cyc == stb)
- ws_DDRack  in  1, ws_DDRdout  in  LINE_W
- ws_SRAMaddr  out  INDEX_W  line index
- ws_SRAMdin  out  LINE_W, ws_SRAMdm  out  LINE_BYTES
- ws_SRAMstb, ws_SRAMwe  out  1
- ws_SRAMack  in  1, ws_SRAMdout  in  LINE_W
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W  saturating statistics

## Operation
- Reset: every output is 0. State goes to INIT; tag array contents are don't-care.
- INIT: clears valid and dirty for one index per cycle (2^INDEX_W cycles), then goes to IDLE. No external strobes and no ws_ack during INIT.
- IDLE: flush_req has priority over ws_stb.
  - On ws_stb: latch addr/din/dm/we and go to LOOKUP.
  - On flush_req: set flush_busy and go to FL_SCAN at index 0.
- LOOKUP (1 cycle): hit = valid && tag match.
  - Hit read: go to SRAM_RD; hit_cnt++.
  - Hit write: SRAM write with dm = ws_dm; dirty=1; go to SRAM_WR; hit_cnt++.
  - Miss, victim valid&dirty: SRAM read of the victim; go to VICT_RD; miss_cnt++.
  - Miss otherwise: go to FILL; miss_cnt++.
- VICT_RD: on SRAM ack, latch line into DDRdin; go to WB.
- WB: DDR write, addr {victim tag, index, 0}, dm all-ones. On ack: wb_cnt++, go to FILL.
- FILL: DDR read of the request line. On ack:
  - Read: SRAM data = DDR data; ws_dout = DDR data.
  - Write: each byte = dm ? din : DDR.
  - SRAM write with full mask; tag updated; valid=1, dirty=we; go to SRAM_WR.
- SRAM_RD: on ack, ws_dout = SRAMdout; go to RESP.
- SRAM_WR: on ack, go to RESP.
- RESP: ws_ack=1 for exactly one cycle; go to IDLE.
- Flush:
  - FL_SCAN: a valid&dirty index goes to FL_RD (SRAM read), then FL_WB (DDR write).
  - FL_WB: on ack, clear dirty and advance the index; wb_cnt++.
  - A clean index advances in 1 cycle.
  - After the last index wraps: flush_busy=0, go to IDLE. Lines stay valid.
- Strobes are decoded from state. SRAM/DDR addr/din/dm are registered when their state is entered and held stable until ack.
- Counters saturate at all-ones and do not wrap.
- rst_n asserted in any state: outputs go to 0 asynchronously. No partial completion is reported. Cache contents are invalidated via INIT.

## Timing
- Hit read with zero-wait SRAM: ws_ack high in the 3rd cycle after the edge sampling ws_stb.
- Each additional SRAM/DDR wait cycle adds one cycle.
- Master must drop ws_stb in the cycle after ws_ack. IDLE re-samples ws_stb one cycle after RESP.
- ack on SRAM/DDR is honoured only while the corresponding stb is high.
- A flush_req that arrives mid-request is taken on the next IDLE.

## Structure
- Package l2_cache_pkg: state encodings, derived-width functions (clog2), counter-saturate helper.
- Sub-module l2_tag_array: 2^INDEX_W × (TAG_W+2) registers.
  - Read port is combinational on index.
  - Write port: index, tag, valid, dirty, we.
  - Separate clear_dirty strobe.
- Top level holds the FSM, merge datapath and counters.

## Test plan
Bench configuration: INDEX_W=2, LINE_BYTES=64, zero-wait SRAM model.
1. Release rst_n with ws_stb already high at addr 0x40 read.
   - No strobes for 4 INIT cycles.
   - DDR read at 0x40 returning 0xA5…A5; ws_dout = 0xA5…A5; miss_cnt=1.
2. Read 0x40 again.
   - No DDRstb; ws_dout = 0xA5…A5; hit_cnt=1; ack 3 cycles after the sampling edge.
3. Write miss at 0x80, dm=0x…000F, din low word 0xDEADBEEF, DDR returns 0x11…11.
   - SRAM write with bytes 0–3 = DEADBEEF and the rest 0x11; dirty set.
4. Read 0x180 (index 2, tag 1).
   - SRAM read, then DDR write at 0x80 with dm all-ones and the merged line from test 3.
   - Then DDR read at 0x180; wb_cnt=1.
5. Lines at indices 1 and 3 dirty; pulse flush_req.
   - Exactly two DDR writes, index 1 then index 3.
   - flush_busy falls after index 3.
   - Re-reads of both lines hit with no DDR traffic.
6. Assert rst_n low during WB with DDRstb high.
   - DDRstb and ws_ack go 0 immediately; counters return to 0.
   - After release, INIT runs again and the first access misses.

Source files
------------

// File: rtl/l2_cache_pkg.sv
// Shared types and helpers for the write-back L2 cache.
package l2_cache_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_VICT_RD, S_WB, S_FILL,
    S_SRAM_RD, S_SRAM_WR, S_RESP, S_FL_SCAN, S_FL_RD, S_FL_WB
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/l2_cache_wb_if.sv
// CPU-side Wishbone-style request bus of the L2 cache.
interface l2_cache_wb_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64
);
  logic [ADDR_W-1:0]       addr;
  logic [8*LINE_BYTES-1:0] din;
  logic [LINE_BYTES-1:0]   dm;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic [8*LINE_BYTES-1:0] dout;

  modport master (output addr, din, dm, stb, we, input ack, dout);
  modport slave  (input addr, din, dm, stb, we, output ack, dout);
endinterface

// File: rtl/l2_tag_array.sv
// Tag/valid/dirty store: combinational read, synchronous write and dirty clear.
module l2_tag_array #(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned TAG_W   = 18
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] index,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  input  logic               we,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic               clear_dirty
);
  localparam int unsigned DEPTH = 1 << INDEX_W;

  logic [TAG_W-1:0] tags [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] dirty;

  assign rd_tag   = tags[index];
  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];

  // No reset here: the INIT sweep of the controller clears valid/dirty.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[index]  <= wr_tag;
      valid[index] <= wr_valid;
      dirty[index] <= wr_dirty;
    end else if (clear_dirty) begin
      dirty[index] <= 1'b0;
    end
  end
endmodule

// File: rtl/l2_cache_wb.sv
// Write-back, write-allocate, direct-mapped L2 cache with flush and statistics.
module l2_cache_wb
  import l2_cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned INDEX_W    = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  l2_cache_wb_if.slave            ws,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic [ADDR_W-1:0]       ws_DDRaddr,
  output logic [8*LINE_BYTES-1:0] ws_DDRdin,
  output logic [LINE_BYTES-1:0]   ws_DDRdm,
  output logic                    ws_DDRcyc,
  output logic                    ws_DDRstb,
  output logic                    ws_DDRwe,
  input  logic                    ws_DDRack,
  input  logic [8*LINE_BYTES-1:0] ws_DDRdout,
  output logic [INDEX_W-1:0]      ws_SRAMaddr,
  output logic [8*LINE_BYTES-1:0] ws_SRAMdin,
  output logic [LINE_BYTES-1:0]   ws_SRAMdm,
  output logic                    ws_SRAMstb,
  output logic                    ws_SRAMwe,
  input  logic                    ws_SRAMack,
  input  logic [8*LINE_BYTES-1:0] ws_SRAMdout,
  output logic [CNT_W-1:0]        hit_cnt,
  output logic [CNT_W-1:0]        miss_cnt,
  output logic [CNT_W-1:0]        wb_cnt
);
  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned OFF_W  = clog2(LINE_BYTES);
  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFF_W;

  state_t state, state_nx;

  logic [ADDR_W-OFF_W-1:0] req_line;
  logic [LINE_W-1:0]       req_din;
  logic [LINE_BYTES-1:0]   req_dm;
  logic                    req_we;
  logic [INDEX_W-1:0]      scan_idx;
  logic [LINE_W-1:0]       dout_q;
  logic [LINE_W-1:0]       merged;

  logic [INDEX_W-1:0] req_idx, idx;
  logic [TAG_W-1:0]   req_tag, rd_tag, ta_tag;
  logic               rd_valid, rd_dirty, hit, scan, scan_last;
  logic               ta_we, ta_valid, ta_dirty, ta_clr;

  assign req_idx   = req_line[INDEX_W-1:0];
  assign req_tag   = req_line[ADDR_W-OFF_W-1 -: TAG_W];
  assign scan      = state inside {S_INIT, S_FL_SCAN, S_FL_RD, S_FL_WB};
  assign idx       = scan ? scan_idx : req_idx;
  assign scan_last = (scan_idx == '1);
  assign hit       = rd_valid && (rd_tag == req_tag);

  l2_tag_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
    .clk(clk), .index(idx), .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
    .we(ta_we), .wr_tag(ta_tag), .wr_valid(ta_valid), .wr_dirty(ta_dirty),
    .clear_dirty(ta_clr)
  );

  always_comb begin
    merged = ws_DDRdout;
    for (int unsigned i = 0; i < LINE_BYTES; i++)
      if (req_we && req_dm[i]) merged[8*i +: 8] = req_din[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ta_we    = 1'b0;
    ta_tag   = req_tag;
    ta_valid = 1'b1;
    ta_dirty = 1'b0;
    ta_clr   = 1'b0;
    case (state)
      S_INIT: begin
        ta_we    = 1'b1;
        ta_valid = 1'b0;
        if (scan_last) state_nx = S_IDLE;
      end
      S_IDLE:
        if (flush_req)   state_nx = S_FL_SCAN;
        else if (ws.stb) state_nx = S_LOOKUP;
      S_LOOKUP:
        if (hit && req_we) begin
          ta_we    = 1'b1;
          ta_dirty = 1'b1;
          state_nx = S_SRAM_WR;
        end else if (hit)               state_nx = S_SRAM_RD;
        else if (rd_valid && rd_dirty)  state_nx = S_VICT_RD;
        else                            state_nx = S_FILL;
      S_VICT_RD: if (ws_SRAMack) state_nx = S_WB;
      S_WB:      if (ws_DDRack)  state_nx = S_FILL;
      S_FILL:
        if (ws_DDRack) begin
          ta_we    = 1'b1;
          ta_dirty = req_we;
          state_nx = S_SRAM_WR;
        end
      S_SRAM_RD, S_SRAM_WR: if (ws_SRAMack) state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      S_FL_SCAN:
        if (rd_valid && rd_dirty) state_nx = S_FL_RD;
        else if (scan_last)       state_nx = S_IDLE;
      S_FL_RD:   if (ws_SRAMack) state_nx = S_FL_WB;
      S_FL_WB:
        if (ws_DDRack) begin
          ta_clr   = 1'b1;
          state_nx = scan_last ? S_IDLE : S_FL_SCAN;
        end
      default:   state_nx = S_INIT;
    endcase
  end

  assign ws_SRAMstb = state inside {S_VICT_RD, S_FL_RD, S_SRAM_RD, S_SRAM_WR};
  assign ws_SRAMwe  = (state == S_SRAM_WR);
  assign ws_DDRstb  = state inside {S_WB, S_FILL, S_FL_WB};
  assign ws_DDRcyc  = ws_DDRstb;
  assign ws_DDRwe   = state inside {S_WB, S_FL_WB};
  assign ws.ack     = (state == S_RESP);
  assign ws.dout    = dout_q;
  assign flush_busy = state inside {S_FL_SCAN, S_FL_RD, S_FL_WB};

  // Bus address/data are loaded on the transition into the state that strobes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_line    <= '0;
      req_din     <= '0;
      req_dm      <= '0;
      req_we      <= 1'b0;
      scan_idx    <= '0;
      dout_q      <= '0;
      ws_DDRaddr  <= '0;
      ws_DDRdin   <= '0;
      ws_DDRdm    <= '0;
      ws_SRAMaddr <= '0;
      ws_SRAMdin  <= '0;
      ws_SRAMdm   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      wb_cnt      <= '0;
    end else begin
      case (state)
        S_INIT: scan_idx <= scan_idx + 1'b1;
        S_IDLE:
          if (flush_req) begin
            scan_idx <= '0;
          end else if (ws.stb) begin
            req_line <= ws.addr[ADDR_W-1:OFF_W];
            req_din  <= ws.din;
            req_dm   <= ws.dm;
            req_we   <= ws.we;
          end
        S_LOOKUP: begin
          ws_SRAMaddr <= req_idx;
          if (hit) begin
            hit_cnt    <= CNT_W'(sat_inc(64'(hit_cnt), CNT_W));
            ws_SRAMdin <= req_din;
            ws_SRAMdm  <= req_we ? req_dm : '0;
          end else begin
            miss_cnt   <= CNT_W'(sat_inc(64'(miss_cnt), CNT_W));
            ws_DDRaddr <= {req_line, {OFF_W{1'b0}}};
            ws_DDRdm   <= '0;
          end
        end
        S_VICT_RD:
          if (ws_SRAMack) begin
            ws_DDRdin  <= ws_SRAMdout;
            ws_DDRaddr <= {rd_tag, req_idx, {OFF_W{1'b0}}};
            ws_DDRdm   <= '1;
          end
        S_WB:
          if (ws_DDRack) begin
            wb_cnt     <= CNT_W'(sat_inc(64'(wb_cnt), CNT_W));
            ws_DDRaddr <= {req_line, {OFF_W{1'b0}}};
            ws_DDRdm   <= '0;
          end
        S_FILL:
          if (ws_DDRack) begin
            ws_SRAMdin <= merged;
            ws_SRAMdm  <= '1;
            if (!req_we) dout_q <= ws_DDRdout;
          end
        S_SRAM_RD: if (ws_SRAMack) dout_q <= ws_SRAMdout;
        S_FL_SCAN:
          if (rd_valid && rd_dirty) ws_SRAMaddr <= scan_idx;
          else                      scan_idx    <= scan_idx + 1'b1;
        S_FL_RD:
          if (ws_SRAMack) begin
            ws_DDRdin  <= ws_SRAMdout;
            ws_DDRaddr <= {rd_tag, scan_idx, {OFF_W{1'b0}}};
            ws_DDRdm   <= '1;
          end
        S_FL_WB:
          if (ws_DDRack) begin
            wb_cnt   <= CNT_W'(sat_inc(64'(wb_cnt), CNT_W));
            scan_idx <= scan_idx + 1'b1;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache_wb.sv
// Directed bench for l2_cache_wb with a zero-wait SRAM and a stallable DDR model.
module tb_l2_cache_wb;
  localparam int unsigned AW = 32, LB = 64, LW = 512, IW = 2, CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_wb_if #(.ADDR_W(AW), .LINE_BYTES(LB)) ws ();

  logic          flush_req = 1'b0, flush_busy;
  logic [AW-1:0] ws_DDRaddr;
  logic [LW-1:0] ws_DDRdin, ws_DDRdout, ws_SRAMdin, ws_SRAMdout;
  logic [LB-1:0] ws_DDRdm, ws_SRAMdm;
  logic          ws_DDRcyc, ws_DDRstb, ws_DDRwe, ws_DDRack;
  logic [IW-1:0] ws_SRAMaddr;
  logic          ws_SRAMstb, ws_SRAMwe, ws_SRAMack;
  logic [CW-1:0] hit_cnt, miss_cnt, wb_cnt;

  l2_cache_wb #(.ADDR_W(AW), .LINE_BYTES(LB), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ws(ws), .flush_req(flush_req), .flush_busy(flush_busy),
    .ws_DDRaddr(ws_DDRaddr), .ws_DDRdin(ws_DDRdin), .ws_DDRdm(ws_DDRdm),
    .ws_DDRcyc(ws_DDRcyc), .ws_DDRstb(ws_DDRstb), .ws_DDRwe(ws_DDRwe),
    .ws_DDRack(ws_DDRack), .ws_DDRdout(ws_DDRdout),
    .ws_SRAMaddr(ws_SRAMaddr), .ws_SRAMdin(ws_SRAMdin), .ws_SRAMdm(ws_SRAMdm),
    .ws_SRAMstb(ws_SRAMstb), .ws_SRAMwe(ws_SRAMwe), .ws_SRAMack(ws_SRAMack),
    .ws_SRAMdout(ws_SRAMdout), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  // Zero-wait SRAM line store
  logic [LW-1:0] sram_mem [4];
  logic [LB-1:0] last_sram_dm;
  logic [IW-1:0] last_sram_addr;
  assign ws_SRAMack  = ws_SRAMstb;
  assign ws_SRAMdout = sram_mem[ws_SRAMaddr];
  always @(posedge clk)
    if (ws_SRAMstb && ws_SRAMwe) begin
      for (int i = 0; i < LB; i++)
        if (ws_SRAMdm[i]) sram_mem[ws_SRAMaddr][8*i +: 8] <= ws_SRAMdin[8*i +: 8];
      last_sram_dm   <= ws_SRAMdm;
      last_sram_addr <= ws_SRAMaddr;
    end

  // DDR model: ack follows stb unless held; completed transfers are logged in order
  logic          ddr_hold = 1'b0;
  logic [LW-1:0] ddr_rdata = '0;
  int            ddr_seq = 0, ddr_stb_cyc = 0;
  logic [AW-1:0] seq_addr [16];
  logic          seq_we   [16];
  logic [LW-1:0] seq_data [16];
  logic [LB-1:0] seq_dm   [16];
  assign ws_DDRack  = ws_DDRstb && !ddr_hold;
  assign ws_DDRdout = ddr_rdata;
  always @(posedge clk) begin
    if (ws_DDRstb) ddr_stb_cyc <= ddr_stb_cyc + 1;
    if (ws_DDRstb && ws_DDRack) begin
      seq_addr[ddr_seq[3:0]] <= ws_DDRaddr;
      seq_we[ddr_seq[3:0]]   <= ws_DDRwe;
      seq_data[ddr_seq[3:0]] <= ws_DDRdin;
      seq_dm[ddr_seq[3:0]]   <= ws_DDRdm;
      ddr_seq <= ddr_seq + 1;
    end
  end

  int checks = 0, failures = 0;
  int lat;
  logic [LW-1:0] rd, line80, line40, lineC0;

  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] d,
                        input logic [LB-1:0] m, output int l, output logic [LW-1:0] r);
    @(negedge clk);
    ws.addr = a; ws.we = w; ws.din = d; ws.dm = m; ws.stb = 1'b1;
    l = 0;
    while (l < 200) begin
      @(posedge clk); #1; l++;
      if (ws.ack) break;
    end
    r = ws.dout;
    checks++;
    if (ws.ack !== 1'b1) begin
      failures++; $display("FAIL req_timeout addr=%h got ack=%b want 1", a, ws.ack);
    end
    ws.stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n, st, s0;
    ws.stb = 1'b0; ws.we = 1'b0; ws.addr = '0; ws.din = '0; ws.dm = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({ws.ack, flush_busy, ws_DDRcyc, ws_DDRstb, ws_DDRwe, ws_SRAMstb, ws_SRAMwe} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got %b want 0",
        {ws.ack, flush_busy, ws_DDRcyc, ws_DDRstb, ws_DDRwe, ws_SRAMstb, ws_SRAMwe});
    end
    checks++;
    if ({ws_DDRaddr, ws_SRAMaddr, hit_cnt, miss_cnt, wb_cnt, ws_DDRdm, ws_SRAMdm} !== '0
        || ws.dout !== '0 || ws_DDRdin !== '0 || ws_SRAMdin !== '0) begin
      failures++; $display("FAIL reset_data got nonzero hit=%0d miss=%0d wb=%0d ddraddr=%h want 0",
        hit_cnt, miss_cnt, wb_cnt, ws_DDRaddr);
    end
    ws.addr = 32'h40; ws.we = 1'b0; ws.stb = 1'b1;
    ddr_rdata = {64{8'hA5}};
    s0 = ddr_seq;
    @(negedge clk); rst_n = 1'b1;
    st = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ws_SRAMstb || ws_DDRstb || ws.ack) st++;
    end
    checks++;
    if (st !== 0) begin failures++; $display("FAIL init_quiet got %0d strobe cycles want 0", st); end
    n = 0;
    while (!ws.ack && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (ws.ack !== 1'b1) begin failures++; $display("FAIL first_ack got %b want 1", ws.ack); end
    checks++;
    if (ws.dout !== {64{8'hA5}}) begin failures++; $display("FAIL first_dout got %h want a5..", ws.dout); end
    checks++;
    if (miss_cnt !== 1 || hit_cnt !== 0) begin
      failures++; $display("FAIL first_cnt got miss=%0d hit=%0d want 1/0", miss_cnt, hit_cnt);
    end
    checks++;
    if (ddr_seq - s0 !== 1 || seq_addr[s0[3:0]] !== 32'h40 || seq_we[s0[3:0]] !== 1'b0) begin
      failures++; $display("FAIL first_ddr got n=%0d addr=%h we=%b want 1/40/0",
        ddr_seq - s0, seq_addr[s0[3:0]], seq_we[s0[3:0]]);
    end
    ws.stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_hit_read();
    int s0;
    s0 = ddr_stb_cyc;
    do_req(32'h40, 1'b0, '0, '0, lat, rd);
    checks++;
    if (rd !== {64{8'hA5}}) begin failures++; $display("FAIL hit_dout got %h want a5..", rd); end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL hit_latency got %0d want 3", lat); end
    checks++;
    if (hit_cnt !== 1) begin failures++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
    checks++;
    if (ddr_stb_cyc !== s0) begin
      failures++; $display("FAIL hit_no_ddr got %0d stb cycles want 0", ddr_stb_cyc - s0);
    end
  endtask

  task automatic test_write_miss();
    logic [LW-1:0] d;
    logic [LB-1:0] m;
    int s0;
    d = '0; d[31:0] = 32'hDEADBEEF;
    m = '0; m[3:0] = 4'hF;
    line80 = {{60{8'h11}}, 32'hDEADBEEF};
    ddr_rdata = {64{8'h11}};
    s0 = ddr_seq;
    do_req(32'h80, 1'b1, d, m, lat, rd);
    checks++;
    if (sram_mem[2] !== line80) begin failures++; $display("FAIL wmiss_merge got %h want %h", sram_mem[2], line80); end
    checks++;
    if (last_sram_dm !== {LB{1'b1}} || last_sram_addr !== 2'd2) begin
      failures++; $display("FAIL wmiss_sram got dm=%h addr=%0d want all-ones/2", last_sram_dm, last_sram_addr);
    end
    checks++;
    if (ddr_seq - s0 !== 1 || seq_addr[s0[3:0]] !== 32'h80 || seq_we[s0[3:0]] !== 1'b0 || miss_cnt !== 2) begin
      failures++; $display("FAIL wmiss_fill got n=%0d addr=%h miss=%0d want 1/80/2",
        ddr_seq - s0, seq_addr[s0[3:0]], miss_cnt);
    end
  endtask

  task automatic test_victim_wb();
    int s0, s1;
    ddr_rdata = {64{8'h22}};
    s0 = ddr_seq;
    s1 = (s0 + 1) % 16;
    do_req(32'h180, 1'b0, '0, '0, lat, rd);
    checks++;
    if (ddr_seq - s0 !== 2) begin failures++; $display("FAIL wb_count got %0d ddr ops want 2", ddr_seq - s0); end
    checks++;
    if (seq_addr[s0[3:0]] !== 32'h80 || seq_we[s0[3:0]] !== 1'b1 || seq_dm[s0[3:0]] !== {LB{1'b1}}) begin
      failures++; $display("FAIL wb_addr got addr=%h we=%b dm=%h want 80/1/all-ones",
        seq_addr[s0[3:0]], seq_we[s0[3:0]], seq_dm[s0[3:0]]);
    end
    checks++;
    if (seq_data[s0[3:0]] !== line80) begin failures++; $display("FAIL wb_data got %h want %h", seq_data[s0[3:0]], line80); end
    checks++;
    if (seq_addr[s1] !== 32'h180 || seq_we[s1] !== 1'b0) begin
      failures++; $display("FAIL wb_fill got addr=%h we=%b want 180/0", seq_addr[s1], seq_we[s1]);
    end
    checks++;
    if (rd !== {64{8'h22}} || wb_cnt !== 1 || miss_cnt !== 3) begin
      failures++; $display("FAIL wb_result got wb=%0d miss=%0d dout=%h want 1/3/22..", wb_cnt, miss_cnt, rd);
    end
  endtask

  task automatic test_flush();
    int s0, s1, n, st;
    for (int i = 0; i < 64; i++) begin
      line40[8*i +: 8] = (i >= 8 && i < 16) ? 8'h5A : 8'hA5;
      lineC0[8*i +: 8] = (i == 0) ? 8'h77 : 8'h33;
    end
    ddr_rdata = {64{8'h33}};
    do_req(32'h40, 1'b1, {64{8'h5A}}, 64'hFF00, lat, rd);
    do_req(32'hC0, 1'b1, {64{8'h77}}, 64'h1, lat, rd);
    s0 = ddr_seq;
    s1 = (s0 + 1) % 16;
    @(negedge clk); flush_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (flush_busy !== 1'b1) begin failures++; $display("FAIL flush_busy_rise got %b want 1", flush_busy); end
    @(negedge clk); flush_req = 1'b0;
    n = 0;
    while (flush_busy && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (flush_busy !== 1'b0) begin failures++; $display("FAIL flush_busy_fall got %b want 0", flush_busy); end
    checks++;
    if (ddr_seq - s0 !== 2 || wb_cnt !== 3) begin
      failures++; $display("FAIL flush_count got ops=%0d wb=%0d want 2/3", ddr_seq - s0, wb_cnt);
    end
    checks++;
    if (seq_addr[s0[3:0]] !== 32'h40 || seq_we[s0[3:0]] !== 1'b1 || seq_data[s0[3:0]] !== line40) begin
      failures++; $display("FAIL flush_first got addr=%h we=%b want 40/1", seq_addr[s0[3:0]], seq_we[s0[3:0]]);
    end
    checks++;
    if (seq_addr[s1] !== 32'hC0 || seq_we[s1] !== 1'b1 || seq_data[s1] !== lineC0) begin
      failures++; $display("FAIL flush_second got addr=%h we=%b want c0/1", seq_addr[s1], seq_we[s1]);
    end
    st = ddr_stb_cyc;
    do_req(32'h40, 1'b0, '0, '0, lat, rd);
    checks++;
    if (rd !== line40 || lat !== 3) begin failures++; $display("FAIL flush_reread40 got lat=%0d dout=%h want 3", lat, rd); end
    do_req(32'hC0, 1'b0, '0, '0, lat, rd);
    checks++;
    if (rd !== lineC0) begin failures++; $display("FAIL flush_rereadC0 got %h want %h", rd, lineC0); end
    checks++;
    if (ddr_stb_cyc !== st || hit_cnt !== 4) begin
      failures++; $display("FAIL flush_hits got ddr_cycles=%0d hit=%0d want 0/4", ddr_stb_cyc - st, hit_cnt);
    end
  endtask

  task automatic test_reset_mid_wb();
    int n, st;
    do_req(32'h180, 1'b1, {64{8'h99}}, 64'h1, lat, rd);
    ddr_hold = 1'b1;
    @(negedge clk);
    ws.addr = 32'h280; ws.we = 1'b0; ws.stb = 1'b1;
    n = 0;
    while (!(ws_DDRstb && ws_DDRwe) && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!(ws_DDRstb && ws_DDRwe && ws_DDRcyc) || ws_DDRaddr !== 32'h180) begin
      failures++; $display("FAIL stall_wb got stb=%b we=%b addr=%h want 1/1/180", ws_DDRstb, ws_DDRwe, ws_DDRaddr);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (ws_DDRstb !== 1'b0 || ws_DDRcyc !== 1'b0 || ws.ack !== 1'b0 || ws_DDRaddr !== '0) begin
      failures++; $display("FAIL async_reset got stb=%b cyc=%b ack=%b addr=%h want 0", ws_DDRstb, ws_DDRcyc, ws.ack, ws_DDRaddr);
    end
    checks++;
    if (hit_cnt !== 0 || miss_cnt !== 0 || wb_cnt !== 0) begin
      failures++; $display("FAIL async_cnt got hit=%0d miss=%0d wb=%0d want 0", hit_cnt, miss_cnt, wb_cnt);
    end
    ws.stb = 1'b0; ddr_hold = 1'b0;
    ddr_rdata = {64{8'h44}};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    st = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ws_SRAMstb || ws_DDRstb || ws.ack) st++;
    end
    checks++;
    if (st !== 0) begin failures++; $display("FAIL reinit_quiet got %0d strobe cycles want 0", st); end
    do_req(32'h40, 1'b0, '0, '0, lat, rd);
    checks++;
    if (miss_cnt !== 1 || hit_cnt !== 0 || rd !== {64{8'h44}}) begin
      failures++; $display("FAIL reinit_miss got miss=%0d hit=%0d dout=%h want 1/0/44..", miss_cnt, hit_cnt, rd);
    end
  endtask

  initial begin
    test_reset();
    test_hit_read();
    test_write_miss();
    test_victim_wb();
    test_flush();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
